// File: rtl/cmd_fetch_buffer_if.sv
// rtl/cmd_fetch_buffer_if.sv - handshake and memory bus bundle for cmd_fetch_buffer
interface cmd_fetch_buffer_if #(
    parameter int CMD_ADDR_WIDTH = 8,
    parameter int MEM_WIDTH      = 32,
    parameter int MEM_TO_CMD     = 4
);
    localparam int CMD_WIDTH      = MEM_WIDTH * MEM_TO_CMD;
    localparam int MEM_ADDR_WIDTH = CMD_ADDR_WIDTH + $clog2(MEM_TO_CMD);

    // Core-side control
    logic                      fetch_en;
    logic                      jump;
    logic [CMD_ADDR_WIDTH-1:0] instr_ptr;

    // Command memory read port
    logic                      mem_ren;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [MEM_WIDTH-1:0]      mem_rdata;

    // Command delivery to the core
    logic [CMD_WIDTH-1:0]      cmd_out;
    logic [CMD_ADDR_WIDTH-1:0] cmd_addr;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      busy;

    // The fetch buffer itself
    modport master (
        input  fetch_en, jump, instr_ptr, mem_rdata, cmd_ready,
        output mem_ren, mem_addr, cmd_out, cmd_addr, cmd_valid, busy
    );

    // The core and command memory around it
    modport slave (
        output fetch_en, jump, instr_ptr, mem_rdata, cmd_ready,
        input  mem_ren, mem_addr, cmd_out, cmd_addr, cmd_valid, busy
    );
endinterface

// File: rtl/cmd_fetch_buffer.sv
// rtl/cmd_fetch_buffer.sv - sequential wide-command fetcher with prefetch FIFO and jump flush
module cmd_fetch_buffer #(
    parameter int CMD_ADDR_WIDTH   = 8,
    parameter int MEM_WIDTH        = 32,
    parameter int MEM_TO_CMD       = 4,
    parameter int MEM_READ_LATENCY = 1,
    parameter int FIFO_DEPTH       = 2
) (
    input logic                 clk,
    input logic                 reset_n,
    cmd_fetch_buffer_if.master  bus
);
    localparam int CMD_WIDTH = MEM_WIDTH * MEM_TO_CMD;
    localparam int WIDX_BITS = $clog2(MEM_TO_CMD);
    localparam int WIDX_W    = (WIDX_BITS > 0) ? WIDX_BITS : 1;
    localparam int LAT       = MEM_READ_LATENCY;
    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1) + 1;

    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(MEM_TO_CMD - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    // Issue side
    logic [0:0]                state_q, state_d;
    logic [CMD_ADDR_WIDTH-1:0] fp_q, fp_d;
    logic [WIDX_W-1:0]         widx_q, widx_d;
    logic [CNT_W-1:0]          pend_q, pend_d;   // commands started but not yet pushed

    // Return side
    logic [LAT-1:0]            rv_q, rv_d;
    logic [WIDX_W-1:0]         ret_idx_q, ret_idx_d;
    logic [CMD_ADDR_WIDTH-1:0] ret_addr_q, ret_addr_d;
    logic [CMD_WIDTH-1:0]      asm_q, asm_d;
    logic [CMD_WIDTH-1:0]      asm_merged;

    // Prefetch FIFO
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CMD_WIDTH-1:0]      fifo_cmd_q  [FIFO_DEPTH];
    logic [CMD_ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];

    logic issue;
    logic slot_ok;
    logic start;
    logic push;
    logic pop;
    logic valid;

    assign issue   = (state_q == S_ISSUE);
    assign valid   = (cnt_q != '0);
    assign pop     = valid && bus.cmd_ready;
    // Reserve a FIFO slot per command before its first word is requested, so a push can never overflow.
    assign slot_ok = bus.fetch_en && ((cnt_q + pend_q) < DEPTH_C);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Fetch FSM: walks the words of each command, starting another only while a slot is reserved.
    always_comb begin
        state_d = state_q;
        fp_d    = fp_q;
        widx_d  = widx_q;
        start   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (slot_ok) begin
                    state_d = S_ISSUE;
                    start   = 1'b1;
                end
            end
            default: begin
                if (widx_q == WIDX_LAST) begin
                    widx_d = '0;
                    fp_d   = fp_q + CMD_ADDR_WIDTH'(1);
                    if (slot_ok) begin
                        start = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    widx_d = widx_q + WIDX_W'(1);
                end
            end
        endcase
        pend_d = pend_q + CNT_W'(start) - CNT_W'(push);
        if (bus.jump) begin
            state_d = S_IDLE;
            fp_d    = bus.instr_ptr;
            widx_d  = '0;
            pend_d  = '0;
        end
    end

    // Return path: track read latency, drop each returning word into its slice, push on the last word.
    always_comb begin
        asm_merged = asm_q;
        asm_merged[int'(ret_idx_q) * MEM_WIDTH +: MEM_WIDTH] = bus.mem_rdata;
        rv_d       = rv_q << 1;
        rv_d[0]    = issue;
        ret_idx_d  = ret_idx_q;
        ret_addr_d = ret_addr_q;
        asm_d      = asm_q;
        push       = 1'b0;
        if (rv_q[LAT-1]) begin
            asm_d = asm_merged;
            if (ret_idx_q == WIDX_LAST) begin
                ret_idx_d  = '0;
                ret_addr_d = ret_addr_q + CMD_ADDR_WIDTH'(1);
                push       = 1'b1;
            end else begin
                ret_idx_d = ret_idx_q + WIDX_W'(1);
            end
        end
        if (bus.jump) begin
            rv_d       = '0;
            ret_idx_d  = '0;
            ret_addr_d = bus.instr_ptr;
            asm_d      = '0;
            push       = 1'b0;
        end
    end

    // FIFO bookkeeping; a jump empties it even if the head is being accepted this cycle.
    always_comb begin
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        if (bus.jump) begin
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    // State registers, all discarded at once by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            fp_q       <= '0;
            widx_q     <= '0;
            pend_q     <= '0;
            rv_q       <= '0;
            ret_idx_q  <= '0;
            ret_addr_q <= '0;
            asm_q      <= '0;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fp_q       <= fp_d;
            widx_q     <= widx_d;
            pend_q     <= pend_d;
            rv_q       <= rv_d;
            ret_idx_q  <= ret_idx_d;
            ret_addr_q <= ret_addr_d;
            asm_q      <= asm_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // FIFO storage; contents are only visible through the valid-gated outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_cmd_q[wr_ptr_q]  <= asm_merged;
            fifo_addr_q[wr_ptr_q] <= ret_addr_q;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset_n)
        push |-> (cnt_q < DEPTH_C));

    generate
        if (MEM_TO_CMD > 1) begin : g_addr_wide
            assign bus.mem_addr = {fp_q, widx_q};
        end else begin : g_addr_narrow
            assign bus.mem_addr = fp_q;
        end
    endgenerate

    assign bus.mem_ren   = issue;
    assign bus.cmd_valid = valid;
    assign bus.cmd_out   = valid ? fifo_cmd_q[rd_ptr_q]  : '0;
    assign bus.cmd_addr  = valid ? fifo_addr_q[rd_ptr_q] : '0;
    assign bus.busy      = issue || (rv_q != '0) || (ret_idx_q != '0);
endmodule

// File: doc/cmd_fetch_buffer.md
# cmd_fetch_buffer

Sequential command fetcher between the processor core and its narrow command memory. Each wide command occupies MEM_TO_CMD consecutive MEM_WIDTH-bit memory words. The block issues the word reads, tolerates a configurable memory read latency and assembles the words into a CMD_WIDTH-bit command. Assembled commands are held in a small prefetch FIFO and presented to the core over a valid/ready handshake, with a jump input that redirects fetch and flushes stale commands.

## Interface
- CMD_ADDR_WIDTH, 8, command address width; command address space wraps modulo 2^CMD_ADDR_WIDTH
- MEM_WIDTH, 32, memory word width
- MEM_TO_CMD, 4, words per command; power of 2, ≥1
- MEM_READ_LATENCY, 1, cycles from mem_ren to mem_rdata; 1..4
- FIFO_DEPTH, 2, prefetched command slots; ≥1
- derived: CMD_WIDTH = MEM_WIDTH*MEM_TO_CMD; MEM_ADDR_WIDTH = CMD_ADDR_WIDTH + log2(MEM_TO_CMD)
- clk  in  1  sole clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- fetch_en  in  1  permits new command fetches
- jump  in  1  single-cycle pulse: redirect fetch to instr_ptr, flush
- instr_ptr  in  CMD_ADDR_WIDTH  jump target command address
- mem_ren  out  1  memory read strobe
- mem_addr  out  MEM_ADDR_WIDTH  word address {cmd_addr, word_idx}
- mem_rdata  in  MEM_WIDTH  read data, valid MEM_READ_LATENCY cycles after mem_ren
- cmd_out  out  CMD_WIDTH  head-of-FIFO command
- cmd_addr  out  CMD_ADDR_WIDTH  command address of cmd_out
- cmd_valid  out  1  cmd_out/cmd_addr valid
- cmd_ready  in  1  core accepts head command
- busy  out  1  reads in flight or partial command in assembly

## Operation
- Registers: fetch pointer fp; word index widx (log2(MEM_TO_CMD) bits); assembly register; read-valid shift register rv[MEM_READ_LATENCY]; return word counter; FIFO of {addr, cmd} with count.
- FSM IDLE/ISSUE. IDLE→ISSUE when fetch_en=1 and FIFO count + commands in flight/assembling < FIFO_DEPTH. In ISSUE: mem_ren=1, mem_addr={fp,widx}, widx++. On widx=MEM_TO_CMD-1: fp++ (wraps), widx←0, and either stay in ISSUE if the slot condition still holds for the next command or return to IDLE. fetch_en low does not abort a command already in ISSUE; its remaining words are issued.
- Return path: rv shifts mem_ren; when rv tail=1, mem_rdata is written to assembly bits [MEM_WIDTH*(k+1)-1 : MEM_WIDTH*k], where k is the return word counter. Word 0 goes to the LSBs. When k=MEM_TO_CMD-1, the command and its address are pushed to the FIFO next cycle.
- Handshake: pop when cmd_valid & cmd_ready. The head is stable while cmd_valid=1 and cmd_ready=0. A push and pop in the same cycle leave the count unchanged. Push to a full FIFO cannot occur by construction; assert this in simulation.
- jump (highest priority): at the clock edge where jump=1:
  - fp←instr_ptr, widx←0, FSM→IDLE.
  - rv cleared, so returning stale words are discarded.
  - Assembly and return counters cleared; FIFO emptied.
  - A pop handshake in the same cycle still counts as accepted.
  - A jump during ISSUE abandons the partial command.
- Reset values: fp=0, widx=0, FSM=IDLE, rv=0, FIFO empty. Outputs: mem_ren=0, mem_addr=0, cmd_valid=0, cmd_out=0, cmd_addr=0, busy=0. Fetch starts from address 0 once fetch_en=1. Reset asserted mid-fetch discards everything immediately (asynchronous).
- busy=1 iff FSM=ISSUE, rv≠0, or return counter≠0.

## Timing
- jump at edge T: first mem_ren in cycle T+1; last word issued T+MEM_TO_CMD; cmd_valid high in cycle T+MEM_TO_CMD+MEM_READ_LATENCY+1 (T+6 for defaults).
- Throughput: with cmd_ready=1 and FIFO_DEPTH≥2, one command per MEM_TO_CMD cycles, mem_ren continuously high.
- With FIFO_DEPTH=1: no fetch issued while the slot is occupied or in flight; the gap after a pop is MEM_TO_CMD+MEM_READ_LATENCY+1 cycles.
- fp wrap: after 2^CMD_ADDR_WIDTH-1, next fetch is address 0; mem_addr wraps identically.

## Test plan
- Reset, fetch_en=1, memory word at address a = a, cmd_ready=1, defaults → first cmd_out=0x00000003_00000002_00000001_00000000, cmd_addr=0 at cycle 6; then cmd_addr=1,2,… every 4 cycles.
- cmd_ready=0 for 20 cycles, FIFO_DEPTH=2 → exactly 8 mem_ren pulses, then mem_ren=0 and busy=0. cmd_addr=0 held stable. Release ready → 0,1,2 delivered in order, no gaps.
- jump with instr_ptr=0x40 while word 2 of cmd 5 is in flight → no command 5 ever appears; next cmd_addr=0x40, cmd_valid at jump+6, FIFO flushed.
- jump coinciding with pop of cmd 3 → cmd 3 counted as consumed once; next delivered cmd_addr=instr_ptr.
- instr_ptr=0xFF jump, MEM_READ_LATENCY=3 → cmd_addr sequence 0xFF,0x00,0x01; mem_addr 0x3FC..0x3FF then 0x000. First valid at jump+8.
- reset_n low mid-assembly, then high → all outputs zero immediately; fetch restarts at cmd_addr 0 with no stale data.
